// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - load-use / HI-LO stall and EX operand forwarding control
//
// Tracks the in-flight writers in EX and MEM, stalls the front end on a
// load-use hazard (and, with HAZARD_MULDIV_EN defined, while the mul/div unit
// is busy and ID wants HI/LO or another mul/div), and registers the EX operand
// forwarding selects at issue.
//
// Optional feature macro: HAZARD_MULDIV_EN (busy counter, HI/LO hazard,
// muldiv_busy). Undefined: no counter, muldiv_busy = 0.
//
// Ports:
//   clk, rst                 core clock, async active-high reset
//   id_valid                 ID holds a real instruction
//   id_rs/id_rt, id_use_*    ID source registers and their read enables
//   id_wreg, id_wen          ID destination register and write enable
//   id_is_load               ID instruction is a load (result at WB)
//   id_is_muldiv             ID instruction starts the mul/div unit
//   id_reads_hilo            ID instruction reads HI/LO
//   flush                    squash the ID instruction
//   stall                    hold PC and IF/ID, bubble into EX
//   ex_fwd_rs, ex_fwd_rt     EX mux selects: 0 regfile, 1 EX/MEM, 2 MEM/WB
//   muldiv_busy              mul/div busy counter is non-zero
module hazard_forward_ctrl #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic [4:0] id_wreg,
  input  logic       id_wen,
  input  logic       id_is_load,
  input  logic       id_is_muldiv,
  input  logic       id_reads_hilo,
  input  logic       flush,
  output logic       stall,
  output logic [1:0] ex_fwd_rs,
  output logic [1:0] ex_fwd_rt,
  output logic       muldiv_busy
);

  // Each entry keeps only the "is a writer" qualifier (valid & wen & wreg != 0)
  // plus what consumers need. The WB entry feeds nothing here: the register
  // file write in WB is visible to the ID read in the same cycle.
  logic       ex_wr_q,   ex_wr_d;
  logic       ex_load_q, ex_load_d;
  logic [4:0] ex_wreg_q, ex_wreg_d;
  logic       mem_wr_q;
  logic [4:0] mem_wreg_q;
  logic [1:0] fwd_rs_q, fwd_rs_d;
  logic [1:0] fwd_rt_q, fwd_rt_d;

  logic load_use;
  logic hilo_haz;
  logic issue;

  // Newer producer (EX, becoming MEM) wins over older (MEM, becoming WB).
  function automatic logic [1:0] fwd_sel(
    input logic       use_r,
    input logic [4:0] r,
    input logic       exw,
    input logic [4:0] exr,
    input logic       memw,
    input logic [4:0] memr
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (use_r && (r != 5'd0)) begin
      if (exw && (exr == r))        sel = 2'd1;
      else if (memw && (memr == r)) sel = 2'd2;
    end
    return sel;
  endfunction

  // ex_wreg_q is non-zero whenever ex_wr_q is set, so a $0 read never matches.
  assign load_use = id_valid & ex_wr_q & ex_load_q &
                    ((id_use_rs & (id_rs == ex_wreg_q)) |
                     (id_use_rt & (id_rt == ex_wreg_q)));

  assign stall = id_valid & ~flush & (load_use | hilo_haz);
  assign issue = id_valid & ~flush & ~stall;

  always_comb begin
    ex_wr_d   = issue & id_wen & (id_wreg != 5'd0);
    ex_load_d = issue & id_is_load;
    ex_wreg_d = issue ? id_wreg : 5'd0;
    fwd_rs_d  = 2'd0;
    fwd_rt_d  = 2'd0;
    if (issue) begin
      fwd_rs_d = fwd_sel(id_use_rs, id_rs, ex_wr_q, ex_wreg_q, mem_wr_q, mem_wreg_q);
      fwd_rt_d = fwd_sel(id_use_rt, id_rt, ex_wr_q, ex_wreg_q, mem_wr_q, mem_wreg_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_wr_q    <= 1'b0;
      ex_load_q  <= 1'b0;
      ex_wreg_q  <= 5'd0;
      mem_wr_q   <= 1'b0;
      mem_wreg_q <= 5'd0;
      fwd_rs_q   <= 2'd0;
      fwd_rt_q   <= 2'd0;
    end else begin
      ex_wr_q    <= ex_wr_d;
      ex_load_q  <= ex_load_d;
      ex_wreg_q  <= ex_wreg_d;
      mem_wr_q   <= ex_wr_q;
      mem_wreg_q <= ex_wreg_q;
      fwd_rs_q   <= fwd_rs_d;
      fwd_rt_q   <= fwd_rt_d;
    end
  end

  assign ex_fwd_rs = fwd_rs_q;
  assign ex_fwd_rt = fwd_rt_q;

`ifdef HAZARD_MULDIV_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Flush does not touch the counter: the mul/div op has already left ID.
  always_comb begin
    cnt_d = cnt_q;
    if (issue && id_is_muldiv)  cnt_d = CNT_W'(MULDIV_CYCLES);
    else if (cnt_q != '0)       cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign hilo_haz    = (cnt_q != '0) & (id_is_muldiv | id_reads_hilo);
  assign muldiv_busy = (cnt_q != '0);
`else
  logic unused_muldiv_inputs;
  assign unused_muldiv_inputs = id_is_muldiv ^ id_reads_hilo;
  assign hilo_haz    = 1'b0;
  assign muldiv_busy = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - scoreboard bench for hazard_forward_ctrl
module tb_hazard_forward_ctrl;

  localparam int MD_CYCLES = 4;
`ifdef HAZARD_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_wreg = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_wen = 1'b0;
  logic       id_is_load = 1'b0, id_is_muldiv = 1'b0, id_reads_hilo = 1'b0;
  logic       flush = 1'b0;
  logic       stall, muldiv_busy;
  logic [1:0] ex_fwd_rs, ex_fwd_rt;

  hazard_forward_ctrl #(.MULDIV_CYCLES(MD_CYCLES), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wreg(id_wreg), .id_wen(id_wen), .id_is_load(id_is_load),
    .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
    .flush(flush), .stall(stall),
    .ex_fwd_rs(ex_fwd_rs), .ex_fwd_rt(ex_fwd_rt), .muldiv_busy(muldiv_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] wreg;
    logic       wen;
    logic       ld;
    logic       md;
    logic       hilo;
    logic       flush;
  } ins_t;

  typedef struct packed {
    logic       v;
    logic       wen;
    logic [4:0] wreg;
    logic       ld;
  } ent_t;

  typedef struct {
    logic       stall;
    logic [1:0] frs;
    logic [1:0] frt;
    logic       busy;
    int         cyc;
  } exp_t;

  exp_t expq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc_no = 0;

  // Reference model: pipeline as an array of instruction records, EX = [0].
  ent_t pipe [3];
  logic [1:0] m_frs, m_frt;
  int   m_cnt;
  bit   m_issued;

  task automatic chk(input string name, input int act, input int exp, input int cyc);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit is_writer(input ent_t e);
    return e.v && e.wen && (e.wreg != 5'd0);
  endfunction

  function automatic logic [1:0] ref_fwd(input logic use_r, input logic [4:0] r);
    if (!use_r || r == 5'd0) return 2'd0;
    for (int s = 0; s < 2; s++)
      if (is_writer(pipe[s]) && pipe[s].wreg == r) return 2'(s + 1);
    return 2'd0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) pipe[s] = '0;
    m_frs = 2'd0;
    m_frt = 2'd0;
    m_cnt = 0;
    m_issued = 1'b0;
  endtask

  function automatic ins_t mk(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                              input int wreg, input bit wen, input bit ld, input bit md,
                              input bit hilo, input bit fl);
    ins_t x;
    x.valid = v; x.rs = 5'(rs); x.rt = 5'(rt); x.use_rs = urs; x.use_rt = urt;
    x.wreg = 5'(wreg); x.wen = wen; x.ld = ld; x.md = md; x.hilo = hilo; x.flush = fl;
    return x;
  endfunction

  // One ID cycle: drive at negedge, push the outputs expected in this cycle,
  // then advance the model across the coming rising edge.
  task automatic cyc(input ins_t x);
    exp_t e;
    bit lu, hl, st, iss;
    @(negedge clk);
    id_valid = x.valid; id_rs = x.rs; id_rt = x.rt;
    id_use_rs = x.use_rs; id_use_rt = x.use_rt;
    id_wreg = x.wreg; id_wen = x.wen; id_is_load = x.ld;
    id_is_muldiv = x.md; id_reads_hilo = x.hilo; flush = x.flush;
    cyc_no++;
    lu = x.valid && is_writer(pipe[0]) && pipe[0].ld &&
         ((x.use_rs && x.rs == pipe[0].wreg) || (x.use_rt && x.rt == pipe[0].wreg));
    hl = MD_EN && (m_cnt > 0) && (x.md || x.hilo);
    st = x.valid && !x.flush && (lu || hl);
    e.stall = st; e.frs = m_frs; e.frt = m_frt; e.busy = (m_cnt > 0); e.cyc = cyc_no;
    expq.push_back(e);
    iss = x.valid && !x.flush && !st;
    m_issued = iss;
    m_frs = iss ? ref_fwd(x.use_rs, x.rs) : 2'd0;
    m_frt = iss ? ref_fwd(x.use_rt, x.rt) : 2'd0;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = iss ? ent_t'{1'b1, x.wen, x.wreg, x.ld} : ent_t'('0);
    if (MD_EN) begin
      if (iss && x.md)    m_cnt = MD_CYCLES;
      else if (m_cnt > 0) m_cnt = m_cnt - 1;
    end
  endtask

  // Monitor: every cycle the DUT presents its outputs; compare when expected.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("stall", int'(stall), int'(e.stall), e.cyc);
        chk("ex_fwd_rs", int'(ex_fwd_rs), int'(e.frs), e.cyc);
        chk("ex_fwd_rt", int'(ex_fwd_rt), int'(e.frt), e.cyc);
        chk("muldiv_busy", int'(muldiv_busy), int'(e.busy), e.cyc);
      end
    end
  end

  initial begin
    ins_t nop, add3, sub4, unrel, or6, lw7, add8, wr0, rd0, rd0f, mult, mflo, lw3, ldz, rnd;
    int guard;
    model_reset();
    nop   = '0;
    add3  = mk(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0);
    sub4  = mk(1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0);
    unrel = mk(1, 10, 11, 1, 1, 9, 1, 0, 0, 0, 0);
    or6   = mk(1, 3, 3, 1, 1, 6, 1, 0, 0, 0, 0);
    lw7   = mk(1, 1, 0, 1, 0, 7, 1, 1, 0, 0, 0);
    add8  = mk(1, 7, 0, 1, 1, 8, 1, 0, 0, 0, 0);
    wr0   = mk(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0);
    ldz   = mk(1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0);
    rd0   = mk(1, 0, 0, 1, 1, 5, 1, 0, 0, 0, 0);
    rd0f  = mk(1, 0, 0, 1, 1, 5, 1, 0, 0, 0, 1);
    mult  = mk(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0);
    mflo  = mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0);
    lw3   = mk(1, 3, 0, 1, 0, 7, 1, 1, 0, 0, 0);

    // Reset state, sampled mid-cycle with reset held.
    #7;
    chk("reset stall", int'(stall), 0, 0);
    chk("reset ex_fwd_rs", int'(ex_fwd_rs), 0, 0);
    chk("reset ex_fwd_rt", int'(ex_fwd_rt), 0, 0);
    chk("reset muldiv_busy", int'(muldiv_busy), 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // EX->EX forward, MEM->EX forward on both operands.
    cyc(add3); cyc(sub4); cyc(nop); cyc(nop);
    cyc(add3); cyc(unrel); cyc(or6); cyc(nop); cyc(nop);
    // Load-use: add8 held in ID while it stalls one cycle.
    cyc(lw7); cyc(add8); cyc(add8); cyc(nop); cyc(nop);
    // $0 never forwards nor stalls; flushed reader becomes a bubble.
    cyc(wr0); cyc(rd0); cyc(nop);
    cyc(ldz); cyc(rd0); cyc(nop);
    cyc(wr0); cyc(rd0f); cyc(add8); cyc(nop); cyc(nop);
    // mult then mflo; mflo held until it issues.
    cyc(mult);
    guard = 0;
    do begin cyc(mflo); guard++; end while (!m_issued && guard < 12);
    chk("mflo issue bound", int'(m_issued), 1, cyc_no);
    // Back-to-back mul/div.
    cyc(mult);
    guard = 0;
    do begin cyc(mult); guard++; end while (!m_issued && guard < 12);
    chk("mult2 issue bound", int'(m_issued), 1, cyc_no);
    repeat (6) cyc(nop);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rnd = mk($urandom_range(0, 99) < 85, $urandom_range(0, 4), $urandom_range(0, 4),
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 4),
               $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 25,
               $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 8,
               $urandom_range(0, 99) < 10);
      cyc(rnd);
    end
    repeat (6) cyc(nop);

    // Async reset in the middle of a load-use stall (mul/div also busy when built).
    cyc(mult); cyc(add3); cyc(lw3); cyc(add8);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst stall", int'(stall), 0, cyc_no);
    chk("async rst ex_fwd_rs", int'(ex_fwd_rs), 0, cyc_no);
    chk("async rst ex_fwd_rt", int'(ex_fwd_rt), 0, cyc_no);
    chk("async rst muldiv_busy", int'(muldiv_busy), 0, cyc_no);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(add3); cyc(sub4); cyc(nop); cyc(nop);

    @(negedge clk);
    #4;
    chk("scoreboard drained", expq.size(), 0, cyc_no);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core.
- Tracks the destination registers of in-flight instructions in EX, MEM and WB, and produces registered forwarding selects for the EX-stage operand muxes.
- Stalls the front end on load-use hazards and, optionally, while the multi-cycle mul/div unit is busy.
- Sits beside the ID/EX pipeline register and drives the select inputs of the operand forwarding muxes.

Parameters:
- MULDIV_CYCLES, 32: cycles the mul/div unit is busy after a mul/div instruction issues. Legal range 1..63.
- CNT_W, 6: width of the busy counter. Must satisfy 2^CNT_W > MULDIV_CYCLES.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  5  ID source register rs.
- id_rt  in  5  ID source register rt.
- id_use_rs  in  1  the instruction reads rs.
- id_use_rt  in  1  the instruction reads rt.
- id_wreg  in  5  ID destination register.
- id_wen  in  1  the instruction writes id_wreg.
- id_is_load  in  1  the instruction is a load; its result is available only at WB.
- id_is_muldiv  in  1  the instruction starts the mul/div unit.
- id_reads_hilo  in  1  the instruction reads HI/LO.
- flush  in  1  squash the ID instruction (taken branch or jump).
- stall  out  1  hold PC and IF/ID; a bubble enters EX.
- ex_fwd_rs  out  2  EX rs mux select: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result.
- ex_fwd_rt  out  2  EX rt mux select, same encoding as ex_fwd_rs.
- muldiv_busy  out  1  busy counter is non-zero.

Behaviour:
- Scoreboard: three entries, EX, MEM and WB. Each entry holds valid, wreg[4:0] and is_load. An entry counts as a writer only if it is valid, its write enable was set, and wreg != 0.
- Reset: all entries invalid; ex_fwd_rs = ex_fwd_rt = 0; busy counter = 0; stall = 0; muldiv_busy = 0.
- issue = id_valid & !flush & !stall.
- Each rising edge:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= ID fields if issue, else a bubble (valid = 0).
- Load-use hazard (combinational): id_valid, and the EX entry is a load writer, and either:
  - id_use_rs and id_rs == EX.wreg, or
  - id_use_rt and id_rt == EX.wreg.
- HI/LO hazard (combinational): counter != 0, and id_is_muldiv or id_reads_hilo.
- stall = id_valid & !flush & (load-use hazard | HI/LO hazard). Flush wins over stall in the same cycle.
- Forward select for rs, computed at issue and registered into ex_fwd_rs:
  - If id_use_rs = 0 or id_rs = 0: select 0.
  - Else if the current EX entry is a writer with wreg == id_rs: select 1. This entry becomes MEM next cycle. It is never a load here, because a load would have stalled.
  - Else if the current MEM entry is a writer with wreg == id_rs: select 2. This entry becomes WB next cycle.
  - Else: select 0.
  - Newer producer wins when both match.
- ex_fwd_rt: identical rules using id_rt and id_use_rt.
- ex_fwd_* reload to 0 on any cycle without issue (bubble or stall).
- Latency: selects are valid in the cycle the instruction sits in EX, one cycle after issue.
- Busy counter:
  - Loads MULDIV_CYCLES on issue with id_is_muldiv.
  - Otherwise decrements while non-zero, saturating at 0.
  - muldiv_busy = (counter != 0).
  - Flush never clears the counter; the mul/div operation has already left ID.
- Back-to-back mul/div: the second instruction stalls until the counter reaches 0, then issues and reloads the counter.
- Reset asserted mid-operation clears every entry and the counter immediately. It does not wait for a clock edge.

Optional Feature:
- Macro: HAZARD_MULDIV_EN.
- When defined: busy counter, HI/LO hazard and the muldiv_busy output behave as described above.
- When undefined: no counter is built; muldiv_busy is tied to 0; id_is_muldiv and id_reads_hilo are ignored; stall comes from load-use hazards only.

Test Plan:
- Reset, then `add $3,$1,$2` followed by `sub $4,$3,$5` -> when sub is in EX, ex_fwd_rs = 1 and stall is never asserted.
- `add $3`, then an unrelated instruction, then `or $6,$3,$3` -> when or is in EX, ex_fwd_rs = ex_fwd_rt = 2.
- `lw $7`, then `add $8,$7,$0` -> stall = 1 for exactly one cycle, EX gets a bubble, and ex_fwd_rs = 2 when add reaches EX.
- Writer to $0 followed by a reader of $0 -> ex_fwd = 0 and no stall; the same sequence with flush = 1 on the reader -> no stall and EX gets a bubble.
- With HAZARD_MULDIV_EN and MULDIV_CYCLES = 4: `mult`, then `mflo` the next cycle -> muldiv_busy is high for 4 cycles, mflo stalls while busy, and issues the first cycle muldiv_busy = 0.
- Assert rst asynchronously while stall = 1 during a mul/div wait -> stall, muldiv_busy and ex_fwd_* drop to 0 before the next clock edge.
